// File: rtl/fb_write_arbiter_if.sv
// rtl/fb_write_arbiter_if.sv - bus bundle for the frame-buffer write arbiter
//
// Purpose: groups the copy stream, the sprite descriptor handshake and the
//   registered frame-buffer write port of fb_write_arbiter.
// Signals:
//   copy_we, copy_addr[18:0], copy_color[7:0]  copy stream request (priority)
//   spr_valid, spr_ready                       descriptor handshake
//   spr_x[9:0], spr_y[9:0], spr_color[7:0]     descriptor payload
//   fb_we, fb_addr[18:0], fb_color[7:0]        frame-buffer write port
//   busy, blit_done                            status
// Modports:
//   master - copy/descriptor source and frame-buffer sink
//   slave  - the arbiter itself
interface fb_write_arbiter_if;
  logic        copy_we;
  logic [18:0] copy_addr;
  logic [7:0]  copy_color;
  logic        spr_valid;
  logic        spr_ready;
  logic [9:0]  spr_x;
  logic [9:0]  spr_y;
  logic [7:0]  spr_color;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_color;
  logic        busy;
  logic        blit_done;

  modport master (
    output copy_we, copy_addr, copy_color, spr_valid, spr_x, spr_y, spr_color,
    input  spr_ready, fb_we, fb_addr, fb_color, busy, blit_done
  );

  modport slave (
    input  copy_we, copy_addr, copy_color, spr_valid, spr_x, spr_y, spr_color,
    output spr_ready, fb_we, fb_addr, fb_color, busy, blit_done
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - frame-buffer write port arbiter (copy stream vs sprite blitter)
//
// Purpose: the copy stream owns the frame-buffer write port whenever copy_we is
//   high. Sprite descriptors queue in a small FIFO and are expanded into
//   SPR_W x SPR_H single-pixel writes that only use cycles the copy stream
//   leaves idle.
// Ports:
//   clk  - system clock, all state on the rising edge
//   r    - asynchronous active-low reset
//   bus  - fb_write_arbiter_if.slave (copy stream, descriptor handshake,
//          registered fb_* write port, busy, blit_done)
// Optional feature: define FBA_CLIP_EN to suppress writes of pixels falling
//   outside FB_WIDTH x FB_HEIGHT (slots are still consumed). Without it,
//   off-screen pixels write at the wrapped 19-bit address.
module fb_write_arbiter #(
  parameter int SPR_W     = 10,
  parameter int SPR_H     = 10,
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  parameter int QDEPTH    = 4
) (
  input logic          clk,
  input logic          r,
  fb_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, BLIT} state_t;

  state_t state, state_nx;

  // Descriptor FIFO
  logic [9:0]    q_x [QDEPTH];
  logic [9:0]    q_y [QDEPTH];
  logic [7:0]    q_c [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, fifo_ne;

  // Working descriptor and pixel walker
  logic [9:0]  wx, wy;
  logic [7:0]  wc;
  logic [9:0]  dx, dy;
  logic [18:0] pix_addr;
  logic        grant, last_pix, pix_on;

  assign bus.spr_ready = (count < CW'(QDEPTH));
  assign fifo_ne       = (count != '0);
  assign push          = bus.spr_valid && bus.spr_ready;
  assign bus.busy      = fifo_ne || (state != IDLE);
  assign last_pix      = (dx == 10'(SPR_W - 1)) && (dy == 10'(SPR_H - 1));

`ifdef FBA_CLIP_EN
  // Coordinate sums carry an 11th bit so a sprite straddling the edge compares correctly.
  logic [10:0] px, py;
  assign px     = {1'b0, wx} + {1'b0, dx};
  assign py     = {1'b0, wy} + {1'b0, dy};
  assign pix_on = (px < 11'(FB_WIDTH)) && (py < 11'(FB_HEIGHT));
`else
  assign pix_on = 1'b1;
`endif

  always_ff @(posedge clk or negedge r) begin
    if (!r) state <= IDLE;
    else    state <= state_nx;
  end

  // Next state, FIFO pop and grant. The final pixel pops the next descriptor
  // directly so consecutive sprites are separated by a single LOAD cycle.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    grant    = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_ne) begin
          pop      = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: state_nx = BLIT;
      BLIT: begin
        if (!bus.copy_we) begin
          grant = 1'b1;
          if (last_pix) begin
            if (fifo_ne) begin
              pop      = 1'b1;
              state_nx = LOAD;
            end else begin
              state_nx = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FIFO storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_x[wr_ptr] <= bus.spr_x;
      q_y[wr_ptr] <= bus.spr_y;
      q_c[wr_ptr] <= bus.spr_color;
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The only multiply is the per-sprite base in LOAD; the pixel loop steps
  // the address incrementally. Sums are formed at 20 bits and the low 19 kept.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      wx       <= '0;
      wy       <= '0;
      wc       <= '0;
      dx       <= '0;
      dy       <= '0;
      pix_addr <= '0;
    end else begin
      if (pop) begin
        wx <= q_x[rd_ptr];
        wy <= q_y[rd_ptr];
        wc <= q_c[rd_ptr];
      end
      if (state == LOAD) begin
        pix_addr <= 19'(20'(wy) * 20'(FB_WIDTH) + 20'(wx));
        dx       <= '0;
        dy       <= '0;
      end else if (grant) begin
        if (dx < 10'(SPR_W - 1)) begin
          dx       <= dx + 1'b1;
          pix_addr <= 19'(20'(pix_addr) + 20'd1);
        end else begin
          dx       <= '0;
          dy       <= dy + 1'b1;
          pix_addr <= 19'(20'(pix_addr) + 20'(FB_WIDTH - (SPR_W - 1)));
        end
      end
    end
  end

  // Registered write port; a clipped slot drops fb_we but still reports blit_done.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      bus.fb_we     <= 1'b0;
      bus.fb_addr   <= '0;
      bus.fb_color  <= '0;
      bus.blit_done <= 1'b0;
    end else begin
      bus.blit_done <= grant && last_pix;
      if (bus.copy_we) begin
        bus.fb_we    <= 1'b1;
        bus.fb_addr  <= bus.copy_addr;
        bus.fb_color <= bus.copy_color;
      end else if (grant && pix_on) begin
        bus.fb_we    <= 1'b1;
        bus.fb_addr  <= pix_addr;
        bus.fb_color <= wc;
      end else begin
        bus.fb_we <= 1'b0;
      end
    end
  end
endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Arbitrates the frame-buffer write port between the background copy stream (SRAM → frame buffer during active scan) and a queued sprite blitter. Sprite draw descriptors (position, color) are accepted through a valid/ready handshake into a small FIFO. Each descriptor is expanded into a rectangle of single-pixel writes that only use cycles the copy stream leaves idle. The block sits between the copy/pixel path and the frame-buffer write port.

## Interface
Parameters:
- SPR_W, 10: sprite width in pixels.
- SPR_H, 10: sprite height in pixels.
- FB_WIDTH, 640: frame-buffer line pitch and visible width.
- FB_HEIGHT, 480: visible lines.
- QDEPTH, 4: descriptor FIFO depth (power of 2).

Ports:
- clk  in  1  system clock; all state on rising edge.
- r  in  1  reset, asynchronous, active-low.
- copy_we  in  1  copy stream write request; has strict priority.
- copy_addr  in  19  copy stream frame-buffer address.
- copy_color  in  8  copy stream pixel.
- spr_valid  in  1  descriptor offered.
- spr_ready  out  1  FIFO can accept a descriptor.
- spr_x, spr_y  in  10 each  sprite top-left corner.
- spr_color  in  8  sprite fill color.
- fb_we  out  1  frame-buffer write enable (registered).
- fb_addr  out  19  frame-buffer address (registered).
- fb_color  out  8  frame-buffer pixel (registered).
- busy  out  1  FIFO non-empty or FSM not IDLE.
- blit_done  out  1  one-cycle pulse, coincident with a sprite's final pixel slot.

## Operation
- FIFO:
  - Push on spr_valid && spr_ready.
  - spr_ready = (count < QDEPTH), driven from registered count; no bypass.
  - A push and pop in the same cycle leaves count unchanged.
- FSM states: IDLE, LOAD, BLIT.
  - IDLE: if the FIFO is non-empty, pop the head into working registers and go to LOAD.
  - LOAD (1 cycle): base = spr_y*FB_WIDTH + spr_x, registered into the pixel address; dx = dy = 0; go to BLIT.
  - BLIT: advance only in cycles where copy_we == 0 (granted cycle); otherwise hold all state.
- Pixel stepping in BLIT:
  - On a granted cycle, issue the pixel at (spr_x+dx, spr_y+dy).
  - If dx < SPR_W-1: dx+1, addr+1.
  - Otherwise: dx = 0, dy+1, addr += FB_WIDTH-(SPR_W-1).
  - No multiplier is used inside the pixel loop.
- Final pixel: dx == SPR_W-1 && dy == SPR_H-1, granted.
  - Assert blit_done.
  - Go to LOAD if the FIFO is non-empty (pop in the same cycle), else IDLE.
- Output mux, registered: copy_we=1 → fb_* = copy_* with fb_we=1. Else a BLIT grant → fb_we=1, fb_addr = pixel addr, fb_color = spr_color. Else fb_we=0, with fb_addr/fb_color holding their previous values.
- Width rules:
  - Address arithmetic is done at 20 bits; fb_addr takes the low 19 bits.
  - Sprite coordinate sums are computed at 11 bits for the clip compare.

## Timing
- Reset (r low, asynchronous):
  - fb_we=0, fb_addr=0, fb_color=0, busy=0, blit_done=0.
  - FIFO emptied, so spr_ready=1 while r is low.
  - FSM goes to IDLE; dx = dy = 0.
  - Reset mid-blit discards the in-flight descriptor and all queued descriptors.
- Copy latency: copy_* at cycle N appears on fb_* at cycle N+1.
- Blit latency:
  - Descriptor pushed into an empty FIFO at edge N → IDLE pops at N+1 → LOAD at N+2 → first pixel write visible on fb_* at N+4, provided copy_we is low at N+3.
  - An unstalled sprite occupies SPR_W*SPR_H consecutive BLIT cycles.
  - Back-to-back sprites insert exactly one LOAD cycle between them.
- Stall: every cycle with copy_we=1 during BLIT delays all remaining pixels by one cycle. No pixel is lost or duplicated.
- blit_done is high in the same cycle fb_we carries the last pixel slot, including when that pixel is clipped.

## Configuration
- FBA_CLIP_EN defined:
  - A pixel with spr_x+dx >= FB_WIDTH or spr_y+dy >= FB_HEIGHT produces fb_we=0 for its slot.
  - The slot is still consumed and the counters still advance.
- FBA_CLIP_EN undefined:
  - No clip logic.
  - Every pixel writes at the computed address, truncated to 19 bits; off-screen pixels wrap.

## Test plan
- Reset then single descriptor (x=100, y=50, color=8'h1C), copy_we=0: 100 writes. First addr 32100; row 1 starts at 32740; last addr 37869; blit_done pulses once with the last write.
- copy_we toggling 1,0,1,0 during BLIT: copy writes pass through with 1-cycle latency; sprite pixel addresses are strictly sequential; total sprite writes = 100.
- Push 5 descriptors back-to-back while the FSM is stalled by copy_we=1: spr_ready drops after the 4th accept and the 5th waits. Releasing copy_we drains all 5 with one LOAD cycle between sprites and 5 blit_done pulses.
- FBA_CLIP_EN, descriptor x=635, y=475: only 5x5 = 25 writes have fb_we=1; blit_done still fires after 100 slots.
- Without FBA_CLIP_EN, same descriptor: 100 writes, addresses computed unclipped.
- Assert r low during the 37th pixel of a sprite with 2 queued descriptors: fb_we=0 and busy=0 immediately; no writes after release until a new push.
